jtag_user_dr: RTL

Parametrised multi-channel JTAG user data-register block, fed directly by the JTAGG primitive's user-chain signals (JTCK, JTDI, JSHIFT, JUPDATE, JCE, JRTI, JTD).
- Per channel: a DR_WIDTH-bit shift register captures a status word, shifts TDI→TDO, and commits to a shadow output register on update.
- Adds update and run-test-idle strobes and optional shift-length checking.
- Sits between the JTAGG primitive and user logic (LED driver, debug registers); successor to the fixed 3-bit, two-chain LED register.

---
 rtl/jtag_user_dr_if.sv | 32 +++
 rtl/jtag_user_dr.sv | 99 +++++++++
 2 files changed

// File: rtl/jtag_user_dr_if.sv
// Bundle of JTAGG user-chain signals and the per-channel user-side outputs of jtag_user_dr.
// master = JTAGG / user-logic side, slave = the data-register block.
interface jtag_user_dr_if #(
    parameter int CHANNELS = 2,
    parameter int DR_WIDTH = 8
);
    // There is no valid/ready pair here. JTDI/JSHIFT/JUPDATE/JCE/JRTI are level
    // qualifiers sampled on every JTCK rising edge. UPD_STB and RTI_STB are
    // single-cycle strobes. DATA_OUT is valid from the cycle UPD_STB[i] is high
    // and holds until the next commit of that channel.
    logic                         JTDI;
    logic                         JSHIFT;
    logic                         JUPDATE;
    logic [CHANNELS-1:0]          JCE;
    logic [CHANNELS-1:0]          JRTI;
    logic [CHANNELS-1:0]          JTD;
    logic [CHANNELS*DR_WIDTH-1:0] DATA_IN;
    logic [CHANNELS*DR_WIDTH-1:0] DATA_OUT;
    logic [CHANNELS-1:0]          UPD_STB;
    logic [CHANNELS-1:0]          RTI_STB;
    logic [CHANNELS-1:0]          LEN_ERR;

    modport master (
        output JTDI, JSHIFT, JUPDATE, JCE, JRTI, DATA_IN,
        input  JTD, DATA_OUT, UPD_STB, RTI_STB, LEN_ERR
    );

    modport slave (
        input  JTDI, JSHIFT, JUPDATE, JCE, JRTI, DATA_IN,
        output JTD, DATA_OUT, UPD_STB, RTI_STB, LEN_ERR
    );
endinterface

// File: rtl/jtag_user_dr.sv
// Multi-channel JTAG user data register: capture/shift/update per chain, with update and RTI strobes.
// Optional shift-length check enabled by defining JTAG_USER_DR_LENCHK_EN.
module jtag_user_dr #(
    parameter int                  CHANNELS    = 2,
    parameter int                  DR_WIDTH    = 8,
    parameter logic [DR_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic            JTCK,
    input logic            JRST,
    jtag_user_dr_if.slave  bus
);
    logic [DR_WIDTH-1:0] shreg [CHANNELS];
    logic [DR_WIDTH-1:0] dout  [CHANNELS];
    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] upd_stb;
    logic [CHANNELS-1:0] rti_stb;
    logic [CHANNELS-1:0] jrti_q;

`ifdef JTAG_USER_DR_LENCHK_EN
    // Counter saturates at DR_WIDTH+1 so any over-length shift stays distinguishable.
    localparam int CW = $clog2(DR_WIDTH + 2);
    logic [CW-1:0]       cnt [CHANNELS];
    logic [CHANNELS-1:0] len_err;
`endif

    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shreg[i] <= '0;
                dout[i]  <= RESET_VALUE;
`ifdef JTAG_USER_DR_LENCHK_EN
                cnt[i]   <= '0;
`endif
            end
            sel     <= '0;
            upd_stb <= '0;
            rti_stb <= '0;
            jrti_q  <= '0;
`ifdef JTAG_USER_DR_LENCHK_EN
            len_err <= '0;
`endif
        end else begin
            rti_stb <= bus.JRTI & ~jrti_q;
            jrti_q  <= bus.JRTI;
            upd_stb <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                // Commit uses the pre-edge shreg; a simultaneous capture/shift below wins sel.
                if (bus.JUPDATE && sel[i]) begin
                    sel[i] <= 1'b0;
`ifdef JTAG_USER_DR_LENCHK_EN
                    if (cnt[i] == CW'(DR_WIDTH)) begin
                        dout[i]    <= shreg[i];
                        upd_stb[i] <= 1'b1;
                        len_err[i] <= 1'b0;
                    end else begin
                        len_err[i] <= 1'b1;
                    end
`else
                    dout[i]    <= shreg[i];
                    upd_stb[i] <= 1'b1;
`endif
                end
                if (bus.JCE[i]) begin
                    sel[i] <= 1'b1;
                    if (bus.JSHIFT) begin
                        shreg[i] <= {bus.JTDI, shreg[i][DR_WIDTH-1:1]};
`ifdef JTAG_USER_DR_LENCHK_EN
                        if (cnt[i] != CW'(DR_WIDTH + 1))
                            cnt[i] <= cnt[i] + CW'(1);
`endif
                    end else begin
                        shreg[i] <= bus.DATA_IN[i*DR_WIDTH +: DR_WIDTH];
`ifdef JTAG_USER_DR_LENCHK_EN
                        cnt[i]   <= '0;
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        bus.DATA_OUT = '0;
        bus.JTD      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.DATA_OUT[i*DR_WIDTH +: DR_WIDTH] = dout[i];
            bus.JTD[i]                           = shreg[i][0];
        end
    end

    assign bus.UPD_STB = upd_stb;
    assign bus.RTI_STB = rti_stb;

`ifdef JTAG_USER_DR_LENCHK_EN
    assign bus.LEN_ERR = len_err;
`else
    assign bus.LEN_ERR = '0;
`endif
endmodule
